fp16_add_sched: RTL and testbench

Round-robin scheduler that shares one pipelined fp16_add instance between NUM_REQ requesters.
- Accepts at most one operand pair per cycle over per-requester valid/ready.
- Registers the operands into the adder and tracks the owner of each in-flight operation in a tag pipeline.
- Returns each sum to its originating requester on a one-hot response strobe.
- Sits between the vector/accumulate front-ends and the shared fp16_add datapath.

---
 rtl/fp16_add_sched.sv | 172 +++++++++++++++++
 tb/tb_fp16_add_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_add_sched.sv
// Round-robin scheduler that shares one pipelined fp16 adder between NUM_REQ requesters.
// Optional per-requester handshake counters on stat_ops when FP16_ADD_SCHED_STATS_EN is defined.
module fp16_add_sched #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*16-1:0]  req_a,
  input  logic [NUM_REQ*16-1:0]  req_b,
  output logic [15:0]            add_a,
  output logic [15:0]            add_b,
  input  logic [15:0]            add_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_data,
  output logic                   busy,
  output logic [1:0]             state
`ifdef FP16_ADD_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  stat_ops
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   ptr_nx_s;
  logic [15:0]        add_a_r;
  logic [15:0]        add_b_r;
  logic [ADD_LAT:0]   tag_v_r;
  logic [IDX_W-1:0]   tag_idx_r [ADD_LAT+1];

  logic               grant_en_s;
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [15:0]        win_a_s;
  logic [15:0]        win_b_s;
  logic               hs_s;
  logic               pending_s;
  logic               any_tag_s;

  // Round-robin search from ptr_r; the descending loop leaves the nearest valid requester.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      win_found_s = win_found_s | req_valid[(int'(ptr_r) + k) % NUM_REQ];
      win_idx_s   = req_valid[(int'(ptr_r) + k) % NUM_REQ] ?
                    IDX_W'((int'(ptr_r) + k) % NUM_REQ) : win_idx_s;
    end
  end

  // Grant qualification, winner operand select and pointer advance.
  always_comb begin
    grant_en_s = enable & rst_n & (state_r != ST_DRAIN);
    hs_s       = grant_en_s & win_found_s;
    req_ready  = {NUM_REQ{hs_s}} & (ONE_HOT_LSB << win_idx_s);
    win_a_s    = req_a[int'(win_idx_s)*16 +: 16];
    win_b_s    = req_b[int'(win_idx_s)*16 +: 16];
    ptr_nx_s   = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_s + IDX_W'(1);
  end

  // Tag pipeline status and response decode.
  always_comb begin
    pending_s = |tag_v_r[ADD_LAT-1:0];
    any_tag_s = |tag_v_r;
    busy      = any_tag_s | hs_s;
    rsp_valid = tag_v_r[ADD_LAT] ? (ONE_HOT_LSB << tag_idx_r[ADD_LAT]) : '0;
    rsp_data  = add_result;
  end

  // Next-state logic; pending_s counts tags that stay in flight past this edge.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nx_s = hs_s ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!hs_s && !pending_s) begin
          state_nx_s = ST_IDLE;
        end else if (!enable && pending_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!pending_s) begin
          state_nx_s = ST_IDLE;
        end else if (enable) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register, issue registers, pointer and owner-tag shift pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      add_a_r <= 16'h0000;
      add_b_r <= 16'h0000;
      tag_v_r <= '0;
      for (int i = 0; i <= ADD_LAT; i++) begin
        tag_idx_r[i] <= '0;
      end
    end else begin
      state_r      <= state_nx_s;
      tag_v_r      <= {tag_v_r[ADD_LAT-1:0], hs_s};
      tag_idx_r[0] <= win_idx_s;
      for (int i = 1; i <= ADD_LAT; i++) begin
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
      if (hs_s) begin
        ptr_r   <= ptr_nx_s;
        add_a_r <= win_a_s;
        add_b_r <= win_b_s;
      end
    end
  end

  assign add_a = add_a_r;
  assign add_b = add_b_r;
  assign state = state_r;

`ifdef FP16_ADD_SCHED_STATS_EN
  logic [15:0] stat_r [NUM_REQ];

  // Per-requester saturating handshake counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs_s && (win_idx_s == IDX_W'(i)) && (stat_r[i] != 16'hFFFF)) begin
          stat_r[i] <= stat_r[i] + 16'h0001;
        end
      end
    end
  end

  // Pack counters onto the flat stat bus.
  always_comb begin
    stat_ops = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_ops[i*16 +: 16] = stat_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_fp16_add_sched.sv
// Self-checking bench for fp16_add_sched: directed test-plan steps then random traffic,
// checked against a queue-based transaction model and a real-arithmetic fp16 adder.
module tb_fp16_add_sched;

  localparam int N       = 4;
  localparam int ADD_LAT = 2;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [N-1:0]  vld;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] a_bus;
  logic [N*16-1:0] b_bus;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic [15:0]   add_result;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_data;
  logic          busy;
  logic [1:0]    state;
`ifdef FP16_ADD_SCHED_STATS_EN
  logic [N*16-1:0] stat_ops;
`endif

  fp16_add_sched #(.NUM_REQ(N), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst_n(rstn), .enable(en),
    .req_valid(vld), .req_ready(req_ready),
    .req_a(a_bus), .req_b(b_bus),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .state(state)
`ifdef FP16_ADD_SCHED_STATS_EN
    , .stat_ops(stat_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- fp16 reference arithmetic (via reals) ----------------
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real mag;
    int  e;
    int  m;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 0) mag = m * pow2(-24);
    else        mag = (1024 + m) * pow2(e - 25);
    return h[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  x;
    real  q;
    real  frac;
    int   e;
    int   fl;
    s = (r < 0.0);
    x = s ? -r : r;
    if (x >= 65520.0) return {s, 15'h7C00};
    e = 15;
    while (e > -14 && x < pow2(e)) e--;
    q  = x / pow2(e - 10);
    fl = $rtoi(q);
    frac = q - fl;
    if (frac > 0.5 || (frac == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 2048) begin
      e++;
      fl = 1024;
    end
    if (fl < 1024) return {s, 5'd0, 10'(fl)};
    return {s, 5'(e + 15), 10'(fl - 1024)};
  endfunction

  function automatic logic [15:0] fp16_ref(input logic [15:0] a, input logic [15:0] b);
    logic nan_a, nan_b, inf_a, inf_b;
    real  r;
    nan_a = (&a[14:10]) && (|a[9:0]);
    nan_b = (&b[14:10]) && (|b[9:0]);
    inf_a = (&a[14:10]) && !(|a[9:0]);
    inf_b = (&b[14:10]) && !(|b[9:0]);
    if (nan_a || nan_b) return 16'h7E00;
    if (inf_a && inf_b) return (a[15] == b[15]) ? a : 16'h7E00;
    if (inf_a) return a;
    if (inf_b) return b;
    r = h2r(a) + h2r(b);
    if (r == 0.0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    return r2h(r);
  endfunction

  // Shared adder stand-in: ADD_LAT register stages, cleared by the same reset.
  logic [15:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ADD_LAT; i++) add_pipe[i] <= 16'h0000;
    end else begin
      add_pipe[0] <= fp16_ref(add_a, add_b);
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign add_result = add_pipe[ADD_LAT-1];

  // ---------------- transaction model ----------------
  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } op_t;

  op_t         q[$];
  int          cyc_m;
  int          ptr_m;
  logic [1:0]  st_m;
  logic [15:0] la_m;
  logic [15:0] lb_m;
  logic [15:0] cnt_m [N];

  int          n_vec;
  int          n_err;
  int          rsp_total;
  int          drain_cycles;
  logic [N-1:0] last_rsp_v;
  logic [15:0]  last_rsp_d;
  int          grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_cycle();
    int           w;
    int           rem;
    logic         hs;
    logic         resp;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rsp;
    w = -1;
    e_ready = '0;
    if (rstn) begin
      if (en && st_m != 2'd2)
        for (int k = 0; k < N; k++)
          if (w < 0 && vld[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      hs = (w >= 0);
      if (hs) e_ready[w] = 1'b1;
      resp  = (q.size() > 0) && (q[0].cyc + ADD_LAT + 1 == cyc_m);
      e_rsp = resp ? (N'(1) << q[0].idx) : '0;
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rsp);
      if (resp) chk("rsp_data", rsp_data, fp16_ref(q[0].a, q[0].b));
      chk("busy", busy, (q.size() > 0) || hs);
      chk("state", state, st_m);
      chk("add_a", add_a, la_m);
      chk("add_b", add_b, lb_m);
`ifdef FP16_ADD_SCHED_STATS_EN
      for (int i = 0; i < N; i++) chk("stat_ops", stat_ops[i*16 +: 16], cnt_m[i]);
`endif
      if (rsp_valid != '0) begin
        rsp_total++;
        last_rsp_v = rsp_valid;
        last_rsp_d = rsp_data;
      end
      if (req_ready != '0) grant_log.push_back(onehot_idx(req_ready));
      if (state == 2'd2) drain_cycles++;
      if (resp) void'(q.pop_front());
      rem = q.size();
      if (hs) begin
        q.push_back('{idx: w, a: a_bus[w*16 +: 16], b: b_bus[w*16 +: 16], cyc: cyc_m});
        ptr_m = (w + 1) % N;
        la_m  = a_bus[w*16 +: 16];
        lb_m  = b_bus[w*16 +: 16];
        if (cnt_m[w] != 16'hFFFF) cnt_m[w] = cnt_m[w] + 16'h0001;
      end
      case (st_m)
        2'd0: if (hs) st_m = 2'd1;
        2'd1: if (!hs && rem == 0) st_m = 2'd0;
              else if (!en && rem > 0) st_m = 2'd2;
        2'd2: if (rem == 0) st_m = 2'd0;
              else if (en) st_m = 2'd1;
        default: st_m = 2'd0;
      endcase
    end else begin
      q.delete();
      ptr_m = 0;
      st_m  = 2'd0;
      la_m  = 16'h0000;
      lb_m  = 16'h0000;
      for (int i = 0; i < N; i++) cnt_m[i] = 16'h0000;
    end
    cyc_m++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < N; i++) begin
      a_bus[i*16 +: 16] = a;
      b_bus[i*16 +: 16] = b;
    end
  endtask

  int g0;
  int r0;
  int d0;
  int fair_exp[4];

  initial begin
    n_vec = 0; n_err = 0; rsp_total = 0; drain_cycles = 0; cyc_m = 0;
    ptr_m = 0; st_m = 2'd0; la_m = 16'h0000; lb_m = 16'h0000;
    last_rsp_v = '0; last_rsp_d = 16'h0000;
    for (int i = 0; i < N; i++) cnt_m[i] = 16'h0000;
    rstn = 1'b0; en = 1'b0; vld = '0; a_bus = '0; b_bus = '0;
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Single op on requester 0
    en = 1'b1;
    a_bus[15:0] = 16'h3C00; b_bus[15:0] = 16'h3C00;
    vld = 4'b0001;
    tick();
    vld = '0;
    repeat (5) tick();
    chk("single_rsp_valid", last_rsp_v, 4'b0001);
    chk("single_rsp_data", last_rsp_d, 16'h4000);
    chk("single_state", state, 2'd0);

    // Full contention; pointer sits at 1 after the single op
    set_all(16'h4000, 16'hB800);
    g0 = grant_log.size(); r0 = rsp_total;
    vld = 4'b1111;
    repeat (8) tick();
    vld = '0;
    repeat (5) tick();
    chk("rotation_count", grant_log.size() - g0, 8);
    for (int k = 0; k < 8; k++) chk("rotation", grant_log[g0 + k], (1 + k) % 4);
    chk("contention_rsps", rsp_total - r0, 8);
    chk("contention_data", last_rsp_d, 16'h3E00);

    // Pointer fairness: req2/req3, then req1 joins at ptr=3
    fair_exp = '{2, 3, 1, 2};
    g0 = grant_log.size();
    vld = 4'b1100;
    tick();
    vld = 4'b1110;
    repeat (3) tick();
    vld = '0;
    repeat (5) tick();
    for (int k = 0; k < 4; k++) chk("fairness", grant_log[g0 + k], fair_exp[k]);

    // Special values: +inf + -inf
    a_bus[31:16] = 16'h7C00; b_bus[31:16] = 16'hFC00;
    vld = 4'b0010;
    tick();
    vld = '0;
    repeat (5) tick();
    chk("special_rsp_valid", last_rsp_v, 4'b0010);
    chk("special_rsp_data", last_rsp_d, 16'h7E00);

    // Drain: three ops, then enable drops with everyone still valid
    set_all(16'h3C00, 16'h3800);
    vld = 4'b1111;
    repeat (3) tick();
    r0 = rsp_total; d0 = drain_cycles;
    en = 1'b0;
    repeat (6) tick();
    chk("drain_rsps", rsp_total - r0, 3);
    chk("drain_cycles", drain_cycles - d0, 2);
    chk("drain_state", state, 2'd0);
    g0 = grant_log.size();
    en = 1'b1;
    tick();
    vld = '0;
    repeat (5) tick();
    chk("resume_ptr", grant_log[g0], 1);

    // Reset with two ops outstanding
    r0 = rsp_total;
    vld = 4'b0001;
    repeat (2) tick();
    rstn = 1'b0; vld = '0;
    tick();
    rstn = 1'b1;
`ifdef FP16_ADD_SCHED_STATS_EN
    chk("reset_stats", stat_ops, '0);
`endif
    chk("reset_busy", busy, 1'b0);
    repeat (5) tick();
    chk("reset_no_rsp", rsp_total - r0, 0);
    g0 = grant_log.size();
    vld = 4'b1111;
    tick();
    vld = '0;
    chk("reset_ptr", grant_log[g0], 0);
    repeat (5) tick();

    // Random traffic with occasional enable drops and resets
    repeat (400) begin
      rstn  = ($urandom_range(0, 63) != 0);
      en    = ($urandom_range(0, 7) != 0);
      vld   = N'($urandom);
      a_bus = {$urandom, $urandom};
      b_bus = {$urandom, $urandom};
      tick();
    end
    rstn = 1'b1; vld = '0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
